uart_cmd_regfile: RTL and testbench

- Parametrised successor to the UART register mapper: decodes received UART command frames into per-channel PWM/DAC control registers.
- Staged (shadow) registers are copied into the active registers by an explicit commit. A commit to a busy channel is deferred until that channel goes idle.
- Readback frames stream out over a valid/ready byte interface. Malformed frames raise error reporting.
- Sits between the UART frame receiver and the pattern_pwm / pattern_ad9748 channel instances.

---
 rtl/uart_cmd_regfile_if.sv | 21 ++
 rtl/uart_cmd_regfile.sv | 238 +++++++++++++++++++++++
 tb/tb_uart_cmd_regfile.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_regfile_if.sv
// Command-frame input and readback byte stream between the UART frame layer and the register file.
interface uart_cmd_regfile_if #(
  parameter int unsigned _PAYLOAD_BYTES = 11
);
  logic [7:0]                  func_reg;
  logic [8*_PAYLOAD_BYTES-1:0] rev_data;
  logic                        pack_done;
  logic [7:0]                  tx_data;
  logic                        tx_valid;
  logic                        tx_ready;

  modport master (
    output func_reg, rev_data, pack_done, tx_ready,
    input  tx_data, tx_valid
  );

  modport slave (
    input  func_reg, rev_data, pack_done, tx_ready,
    output tx_data, tx_valid
  );
endinterface

// File: rtl/uart_cmd_regfile.sv
// Decodes UART command frames into staged/active per-channel PWM/DAC registers,
// with deferred commits for busy channels and a 12-byte readback stream.
module uart_cmd_regfile #(
  parameter int unsigned _NUM_CHANNELS  = 4,
  parameter int unsigned _PAT_WIDTH     = 32,
  parameter int unsigned _PAYLOAD_BYTES = 11
) (
  input  logic                                 clk_50M,
  input  logic                                 rst,
  uart_cmd_regfile_if.slave                    bus,
  input  logic [_NUM_CHANNELS-1:0]             ch_busy,
  output logic [8*_NUM_CHANNELS-1:0]           hs_ctrl_sta,
  output logic [8*_NUM_CHANNELS-1:0]           duty_num,
  output logic [16*_NUM_CHANNELS-1:0]          pulse_dessert,
  output logic [8*_NUM_CHANNELS-1:0]           pulse_num,
  output logic [_PAT_WIDTH*_NUM_CHANNELS-1:0]  PAT,
  output logic [8*_NUM_CHANNELS-1:0]           ls_ctrl_sta,
  output logic [_NUM_CHANNELS-1:0]             commit_pulse,
  output logic                                 err_pulse,
  output logic [1:0]                           err_code
);

  localparam int unsigned NCH   = _NUM_CHANNELS;
  localparam int unsigned PW    = _PAT_WIDTH;
  localparam int unsigned PAY_W = 8 * _PAYLOAD_BYTES;
  localparam int unsigned CH_W  = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [3:0] LAST_IDX  = 4'd11;
  localparam logic [7:0] FN_STAGE  = 8'h01;
  localparam logic [7:0] FN_LS     = 8'h02;
  localparam logic [7:0] FN_COMMIT = 8'h03;
  localparam logic [7:0] FN_READ   = 8'h04;
  localparam logic [7:0] FN_ABORT  = 8'h05;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state_q, state_d;
  logic [7:0]        func_q;
  logic [PAY_W-1:0]  payload_q;

  logic [7:0]        sh_ctrl_q [NCH];
  logic [7:0]        sh_duty_q [NCH];
  logic [15:0]       sh_des_q  [NCH];
  logic [7:0]        sh_num_q  [NCH];
  logic [PW-1:0]     sh_pat_q  [NCH];

  logic [7:0]        act_ctrl_q [NCH];
  logic [7:0]        act_duty_q [NCH];
  logic [15:0]       act_des_q  [NCH];
  logic [7:0]        act_num_q  [NCH];
  logic [PW-1:0]     act_pat_q  [NCH];
  logic [7:0]        ls_q       [NCH];

  logic [NCH-1:0]    pending_q;
  logic [CH_W-1:0]   rb_ch_q;
  logic [3:0]        idx_q;
  logic [7:0]        tx_data_q;
  logic              tx_valid_q;

  // Payload bytes beyond the ten decoded ones are reserved.
  logic unused_payload;
  assign unused_payload = ^payload_q;

  logic [7:0]      ch_byte_c;
  logic [CH_W-1:0] ch_idx_c;
  logic            ch_ok_c, in_exec_c;
  logic            is_stage_c, is_ls_c, is_commit_c, is_read_c, is_abort_c, known_c;
  logic            err_ch_c, err_fn_c, abort_c, stage_c, ls_wr_c, hs_accept_c, drop_c;
  logic [NCH-1:0]  mask_c, fire_c, pend_set_c;
  logic [31:0]     pat32_c, rb_pat_c;
  logic [3:0]      nidx_c;
  logic [7:0]      rb_byte_c;

  assign ch_byte_c   = payload_q[7:0];
  assign ch_idx_c    = CH_W'(ch_byte_c);
  assign ch_ok_c     = ch_byte_c < 8'(NCH);
  assign in_exec_c   = (state_q == EXEC);
  assign is_stage_c  = (func_q == FN_STAGE);
  assign is_ls_c     = (func_q == FN_LS);
  assign is_commit_c = (func_q == FN_COMMIT);
  assign is_read_c   = (func_q == FN_READ);
  assign is_abort_c  = (func_q == FN_ABORT);
  assign known_c     = is_stage_c | is_ls_c | is_commit_c | is_read_c | is_abort_c;
  assign err_ch_c    = in_exec_c & (is_stage_c | is_ls_c | is_read_c) & ~ch_ok_c;
  assign err_fn_c    = in_exec_c & ~known_c;
  assign stage_c     = in_exec_c & is_stage_c & ch_ok_c;
  assign ls_wr_c     = in_exec_c & is_ls_c & ch_ok_c;
  assign abort_c     = in_exec_c & is_abort_c;
  assign hs_accept_c = tx_valid_q & bus.tx_ready;
  assign pat32_c     = {payload_q[55:48], payload_q[63:56], payload_q[71:64], payload_q[79:72]};

  // Immediate and deferred commits both fire only on idle channels; abort suppresses them.
  assign mask_c     = (in_exec_c && is_commit_c) ? payload_q[NCH-1:0] : '0;
  assign fire_c     = abort_c ? '0 : ((mask_c | pending_q) & ~ch_busy);
  assign pend_set_c = mask_c & ch_busy;

  always_ff @(posedge clk_50M) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    drop_c  = 1'b0;
    case (state_q)
      IDLE: if (bus.pack_done) state_d = EXEC;
      EXEC: begin
        drop_c  = bus.pack_done;
        state_d = (is_read_c && ch_ok_c) ? RESP : IDLE;
      end
      RESP: begin
        drop_c = bus.pack_done;
        if (hs_accept_c && idx_q == LAST_IDX) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Byte to present after the current one is accepted, sampled from live registers.
  always_comb begin
    rb_byte_c = 8'h00;
    nidx_c    = idx_q + 4'd1;
    rb_pat_c  = 32'(act_pat_q[rb_ch_q]);
    case (nidx_c)
      4'd1:    rb_byte_c = 8'(rb_ch_q);
      4'd2:    rb_byte_c = act_ctrl_q[rb_ch_q];
      4'd3:    rb_byte_c = act_duty_q[rb_ch_q];
      4'd4:    rb_byte_c = act_des_q[rb_ch_q][15:8];
      4'd5:    rb_byte_c = act_des_q[rb_ch_q][7:0];
      4'd6:    rb_byte_c = act_num_q[rb_ch_q];
      4'd7:    rb_byte_c = rb_pat_c[31:24];
      4'd8:    rb_byte_c = rb_pat_c[23:16];
      4'd9:    rb_byte_c = rb_pat_c[15:8];
      4'd10:   rb_byte_c = rb_pat_c[7:0];
      4'd11:   rb_byte_c = {6'b0, pending_q[rb_ch_q], ch_busy[rb_ch_q]};
      default: rb_byte_c = 8'h00;
    endcase
  end

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      func_q    <= '0;
      payload_q <= '0;
    end else if (state_q == IDLE && bus.pack_done) begin
      func_q    <= bus.func_reg;
      payload_q <= bus.rev_data;
    end
  end

  // Shadow, active and low-speed register banks; commits read the pre-write shadow.
  always_ff @(posedge clk_50M) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        sh_ctrl_q[i]  <= '0;
        sh_duty_q[i]  <= '0;
        sh_des_q[i]   <= '0;
        sh_num_q[i]   <= '0;
        sh_pat_q[i]   <= '0;
        act_ctrl_q[i] <= '0;
        act_duty_q[i] <= '0;
        act_des_q[i]  <= '0;
        act_num_q[i]  <= '0;
        act_pat_q[i]  <= '0;
        ls_q[i]       <= '0;
      end
      pending_q    <= '0;
      commit_pulse <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (fire_c[i]) begin
          act_ctrl_q[i] <= sh_ctrl_q[i];
          act_duty_q[i] <= sh_duty_q[i];
          act_des_q[i]  <= sh_des_q[i];
          act_num_q[i]  <= sh_num_q[i];
          act_pat_q[i]  <= sh_pat_q[i];
        end
        if (abort_c) act_ctrl_q[i][0] <= 1'b0;
      end
      if (stage_c) begin
        sh_ctrl_q[ch_idx_c] <= payload_q[15:8];
        sh_duty_q[ch_idx_c] <= payload_q[23:16];
        sh_des_q[ch_idx_c]  <= {payload_q[31:24], payload_q[39:32]};
        sh_num_q[ch_idx_c]  <= payload_q[47:40];
        sh_pat_q[ch_idx_c]  <= PW'(pat32_c);
      end
      if (ls_wr_c) ls_q[ch_idx_c] <= payload_q[15:8];
      pending_q    <= abort_c ? '0 : ((pending_q | pend_set_c) & ~fire_c);
      commit_pulse <= fire_c;
    end
  end

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      rb_ch_q    <= '0;
      idx_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else if (in_exec_c && is_read_c && ch_ok_c) begin
      rb_ch_q    <= ch_idx_c;
      idx_q      <= '0;
      tx_data_q  <= 8'hA5;
      tx_valid_q <= 1'b1;
    end else if (state_q == RESP && hs_accept_c) begin
      if (idx_q == LAST_IDX) begin
        tx_valid_q <= 1'b0;
      end else begin
        idx_q     <= nidx_c;
        tx_data_q <= rb_byte_c;
      end
    end
  end

  // A dropped frame outranks a same-cycle decode error in err_code.
  always_ff @(posedge clk_50M) begin
    if (rst) begin
      err_pulse <= 1'b0;
      err_code  <= 2'd0;
    end else begin
      err_pulse <= drop_c | err_ch_c | err_fn_c;
      if (drop_c)        err_code <= 2'd3;
      else if (err_ch_c) err_code <= 2'd1;
      else if (err_fn_c) err_code <= 2'd2;
    end
  end

  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;

  for (genvar g = 0; g < NCH; g++) begin : g_flat
    assign hs_ctrl_sta[8*g +: 8]    = act_ctrl_q[g];
    assign duty_num[8*g +: 8]       = act_duty_q[g];
    assign pulse_dessert[16*g +: 16] = act_des_q[g];
    assign pulse_num[8*g +: 8]      = act_num_q[g];
    assign PAT[PW*g +: PW]          = act_pat_q[g];
    assign ls_ctrl_sta[8*g +: 8]    = ls_q[g];
  end

endmodule

// File: tb/tb_uart_cmd_regfile.sv
// Scoreboard bench for uart_cmd_regfile: register effects, deferred commits, readback stream, errors.
module tb_uart_cmd_regfile;

  localparam logic [95:0] RB1     = 96'hA5_01_01_10_02_03_05_DE_AD_BE_EF_00;
  localparam logic [95:0] RB1_ABT = 96'hA5_01_00_10_02_03_05_DE_AD_BE_EF_00;
  localparam logic [95:0] RB0_PND = 96'hA5_00_00_00_00_00_00_00_00_00_00_03;

  logic        clk_50M = 1'b0;
  logic        rst;
  logic [3:0]  ch_busy;
  logic [31:0] hs_ctrl_sta, duty_num, pulse_num, ls_ctrl_sta;
  logic [63:0] pulse_dessert;
  logic [127:0] PAT;
  logic [3:0]  commit_pulse;
  logic        err_pulse;
  logic [1:0]  err_code;

  uart_cmd_regfile_if #(._PAYLOAD_BYTES(11)) bus();

  uart_cmd_regfile #(._NUM_CHANNELS(4), ._PAT_WIDTH(32), ._PAYLOAD_BYTES(11)) dut (
    .clk_50M(clk_50M), .rst(rst), .bus(bus), .ch_busy(ch_busy),
    .hs_ctrl_sta(hs_ctrl_sta), .duty_num(duty_num), .pulse_dessert(pulse_dessert),
    .pulse_num(pulse_num), .PAT(PAT), .ls_ctrl_sta(ls_ctrl_sta),
    .commit_pulse(commit_pulse), .err_pulse(err_pulse), .err_code(err_code)
  );

  always #10 clk_50M = ~clk_50M;

  int         n_chk = 0;
  int         n_pass = 0;
  logic [7:0] exp_q[$];
  int         rx_count = 0;
  int         cp_cnt[4] = '{0, 0, 0, 0};
  int         err_cnt = 0;
  bit         ready_toggle = 1'b0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_50M);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] fn, input logic [87:0] pl);
    bus.func_reg  = fn;
    bus.rev_data  = pl;
    bus.pack_done = 1'b1;
    tick(1);
    bus.pack_done = 1'b0;
  endtask

  function automatic logic [87:0] mk_hs(input logic [7:0] ch, input logic [7:0] ctrl,
                                        input logic [7:0] duty, input logic [15:0] des,
                                        input logic [7:0] num, input logic [31:0] pat);
    return {8'h00, pat[7:0], pat[15:8], pat[23:16], pat[31:24], num,
            des[7:0], des[15:8], duty, ctrl, ch};
  endfunction

  task automatic readback(input logic [7:0] ch, input logic [95:0] exp);
    for (int i = 0; i < 12; i++) exp_q.push_back(exp[95-8*i -: 8]);
    send(8'h04, 88'(ch));
  endtask

  task automatic wait_stream(input string tag);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || bus.tx_valid) && k < 300) begin
      tick(1);
      k++;
    end
    chk(tag, 64'(exp_q.size()), 64'd0);
  endtask

  // Ready source: always ready, or alternating to exercise stalls.
  initial begin
    bus.tx_ready = 1'b1;
    forever begin
      @(posedge clk_50M);
      #1;
      bus.tx_ready = ready_toggle ? ~bus.tx_ready : 1'b1;
    end
  end

  // Output monitor: scoreboard pops on handshake, stall-stability, pulse counters.
  always @(negedge clk_50M) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("tx_hold_data", 64'(bus.tx_data), 64'(prev_data));
        chk("tx_hold_valid", 64'(bus.tx_valid), 64'd1);
      end
      if (bus.tx_valid && bus.tx_ready) begin
        rx_count++;
        if (exp_q.size() == 0) chk("tx_extra_byte", 64'(exp_q.size()), 64'd1);
        else chk("tx_byte", 64'(bus.tx_data), 64'(exp_q.pop_front()));
      end
      prev_stall = bus.tx_valid && !bus.tx_ready;
      prev_data  = bus.tx_data;
      for (int i = 0; i < 4; i++) if (commit_pulse[i]) cp_cnt[i]++;
      if (err_pulse) err_cnt++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int e0, c0, r0;
    rst = 1'b1;
    ch_busy = 4'h0;
    bus.pack_done = 1'b0;
    bus.func_reg = 8'h00;
    bus.rev_data = '0;
    tick(3);
    chk("rst_hs_ctrl", 64'(hs_ctrl_sta), 64'd0);
    chk("rst_pat", PAT[63:0], 64'd0);
    chk("rst_tx_valid", 64'(bus.tx_valid), 64'd0);
    chk("rst_err_code", 64'(err_code), 64'd0);
    chk("rst_commit", 64'(commit_pulse), 64'd0);
    rst = 1'b0;
    tick(1);

    // Stage ch1 then commit with the channel idle.
    send(8'h01, mk_hs(8'd1, 8'h01, 8'h10, 16'h0203, 8'h05, 32'hDEADBEEF));
    tick(1);
    chk("stage_no_active_ctrl", 64'(hs_ctrl_sta), 64'd0);
    chk("stage_no_active_pat", PAT[63:32], 64'd0);
    send(8'h03, 88'h2);
    chk("commit_t1_pulse", 64'(commit_pulse), 64'd0);
    tick(1);
    chk("commit_ctrl", 64'(hs_ctrl_sta[15:8]), 64'h01);
    chk("commit_duty", 64'(duty_num[15:8]), 64'h10);
    chk("commit_dessert", 64'(pulse_dessert[31:16]), 64'h0203);
    chk("commit_num", 64'(pulse_num[15:8]), 64'h05);
    chk("commit_pat", 64'(PAT[63:32]), 64'hDEADBEEF);
    chk("commit_pulse", 64'(commit_pulse), 64'h2);
    tick(1);
    chk("commit_pulse_end", 64'(commit_pulse), 64'h0);
    chk("commit_pulse_cnt", 64'(cp_cnt[1]), 64'd1);

    // Deferred commit on busy ch0; readback shows pending while busy.
    send(8'h01, mk_hs(8'd0, 8'h03, 8'h22, 16'h1111, 8'h07, 32'h12345678));
    tick(1);
    ch_busy = 4'b0001;
    send(8'h03, 88'h1);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("busy_ctrl0", 64'(hs_ctrl_sta[7:0]), 64'h00);
      chk("busy_pulse0", 64'(commit_pulse[0]), 64'd0);
    end
    readback(8'd0, RB0_PND);
    wait_stream("rb_pending_done");
    ch_busy = 4'b0000;
    tick(1);
    chk("deferred_pulse", 64'(commit_pulse), 64'h1);
    chk("deferred_ctrl0", 64'(hs_ctrl_sta[7:0]), 64'h03);
    chk("deferred_pat0", 64'(PAT[31:0]), 64'h12345678);

    // Readback ch1 under an alternating ready.
    r0 = rx_count;
    ready_toggle = 1'b1;
    readback(8'd1, RB1);
    wait_stream("rb_toggle_done");
    ready_toggle = 1'b0;
    chk("rb_byte_count", 64'(rx_count - r0), 64'd12);
    chk("rb_valid_low", 64'(bus.tx_valid), 64'd0);

    // Bad channel, bad function, out-of-range mask bits.
    e0 = err_cnt;
    send(8'h01, mk_hs(8'd4, 8'hFF, 8'hFF, 16'hFFFF, 8'hFF, 32'hFFFFFFFF));
    tick(2);
    chk("badch_code", 64'(err_code), 64'd1);
    chk("badch_pulses", 64'(err_cnt - e0), 64'd1);
    chk("badch_hs_ctrl", 64'(hs_ctrl_sta), 64'h0000_0103);
    send(8'h07, 88'h0);
    tick(2);
    chk("badfn_code", 64'(err_code), 64'd2);
    chk("badfn_pulses", 64'(err_cnt - e0), 64'd2);
    chk("badfn_pat", PAT[63:0], 64'hDEADBEEF_12345678);
    c0 = cp_cnt[0] + cp_cnt[1] + cp_cnt[2] + cp_cnt[3];
    send(8'h03, 88'hFFFF_FFF0);
    tick(2);
    chk("highmask_pulses", 64'(cp_cnt[0] + cp_cnt[1] + cp_cnt[2] + cp_cnt[3] - c0), 64'd0);
    chk("highmask_no_err", 64'(err_cnt - e0), 64'd2);

    // Frame arriving mid-stream is dropped; stream unaffected.
    readback(8'd1, RB1);
    tick(3);
    send(8'h02, mk_hs(8'd0, 8'h55, 8'h0, 16'h0, 8'h0, 32'h0));
    wait_stream("rb_drop_done");
    chk("drop_code", 64'(err_code), 64'd3);
    chk("drop_no_ls", 64'(ls_ctrl_sta), 64'd0);
    send(8'h02, mk_hs(8'd2, 8'h5A, 8'h0, 16'h0, 8'h0, 32'h0));
    tick(1);
    chk("ls_write", 64'(ls_ctrl_sta), 64'h005A_0000);

    // Abort cancels a pending commit and clears enable bits.
    send(8'h01, mk_hs(8'd2, 8'h01, 8'h44, 16'h0505, 8'h09, 32'hCAFEF00D));
    tick(1);
    ch_busy = 4'b0100;
    send(8'h03, 88'h4);
    tick(1);
    chk("abort_pre_pulse", 64'(commit_pulse), 64'd0);
    send(8'h05, 88'h0);
    tick(1);
    ch_busy = 4'b0000;
    tick(3);
    chk("abort_no_commit", 64'(cp_cnt[2]), 64'd0);
    chk("abort_hs_ctrl", 64'(hs_ctrl_sta), 64'h0000_0002);
    chk("abort_pat2", 64'(PAT[95:64]), 64'd0);

    // Reset in the middle of a readback.
    ready_toggle = 1'b1;
    readback(8'd1, RB1_ABT);
    tick(5);
    rst = 1'b1;
    tick(1);
    exp_q.delete();
    chk("rst_mid_valid", 64'(bus.tx_valid), 64'd0);
    chk("rst_mid_data", 64'(bus.tx_data), 64'd0);
    chk("rst_mid_hs", 64'(hs_ctrl_sta), 64'd0);
    chk("rst_mid_duty", 64'(duty_num), 64'd0);
    chk("rst_mid_dessert", pulse_dessert, 64'd0);
    chk("rst_mid_num", 64'(pulse_num), 64'd0);
    chk("rst_mid_pat", PAT[63:0], 64'd0);
    chk("rst_mid_ls", 64'(ls_ctrl_sta), 64'd0);
    chk("rst_mid_err", 64'(err_code), 64'd0);
    rst = 1'b0;
    ready_toggle = 1'b0;
    tick(3);
    chk("post_rst_valid", 64'(bus.tx_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
